// File: rtl/reg_write_decode_file.sv
// Write-address decode and 32x32 register file with two read ports, a debug port, a written-mask and a write counter.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to read ports A and B.
module reg_write_decode_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [ADDR_W-1:0]      raddr_a,
    input  logic [ADDR_W-1:0]      raddr_b,
    output logic [DATA_W-1:0]      rdata_a,
    output logic [DATA_W-1:0]      rdata_b,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [DATA_W-1:0]      dbg_data,
    output logic [(1<<ADDR_W)-1:0] wr_onehot,
    output logic [(1<<ADDR_W)-1:0] written_mask,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  wr_en_d;
    logic [DEPTH-1:0]  onehot_q;
    logic [DEPTH-1:0]  mask_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // $0 is hardwired, so a write aimed at it decodes to no enable at all.
    always_comb begin
        wr_en_d = '0;
        if (we && (waddr != '0)) begin
            wr_en_d[waddr] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (|wr_en_d) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            onehot_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en_d[i]) begin
                    regs_q[i] <= wdata;
                end
            end
            onehot_q <= wr_en_d;
            mask_q   <= mask_q | wr_en_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        rdata_a  = (raddr_a  == '0) ? '0 : regs_q[raddr_a];
        rdata_b  = (raddr_b  == '0) ? '0 : regs_q[raddr_b];
        dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Debug port deliberately shows only committed contents.
        if (we && (waddr != '0) && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if (we && (waddr != '0) && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`else
`endif
    end

    assign wr_onehot    = onehot_q;
    assign written_mask = mask_q;
    assign wr_count     = count_q;

endmodule

// File: tb/tb_reg_write_decode_file.sv
// Self-checking bench for reg_write_decode_file: directed vector table, hand sequences and randomized model check.
module tb_reg_write_decode_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0, raddr_a = '0, raddr_b = '0, dbg_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_a, rdata_b, dbg_data, wr_onehot, written_mask;
    logic [15:0] wr_count;
    logic [31:0] rdata_a4, rdata_b4, dbg_data4, wr_onehot4, written_mask4;
    logic [3:0]  wr_count4;

    reg_write_decode_file dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_onehot(wr_onehot),
        .written_mask(written_mask), .wr_count(wr_count)
    );

    reg_write_decode_file #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a4), .rdata_b(rdata_b4),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4), .wr_onehot(wr_onehot4),
        .written_mask(written_mask4), .wr_count(wr_count4)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain array, mask word and integer counter.
    logic [31:0] m_regs [32];
    logic [31:0] m_mask, m_onehot;
    int unsigned m_count;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_mask = '0; m_onehot = '0; m_count = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit port_ab);
        if (a == 0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (port_ab && we && waddr != 0 && waddr == a) return wdata;
`else
        if (port_ab) begin end
`endif
        return m_regs[a];
    endfunction

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; dbg_addr = da;
    endtask

    task automatic cycle_model();
        #1;
        chk("rd_a",   rdata_a,  m_read(raddr_a, 1'b1));
        chk("rd_b",   rdata_b,  m_read(raddr_b, 1'b1));
        chk("rd_dbg", dbg_data, m_read(dbg_addr, 1'b0));
        chk("rd_a4",  rdata_a4, m_read(raddr_a, 1'b1));
        chk("rd_b4",  rdata_b4, m_read(raddr_b, 1'b1));
        chk("rd_dbg4", dbg_data4, m_read(dbg_addr, 1'b0));
        @(posedge clk);
        if (we && waddr != 0) begin
            m_regs[waddr] = wdata;
            m_onehot = 32'h1 << waddr;
            m_mask |= m_onehot;
            m_count++;
        end else begin
            m_onehot = '0;
        end
        #1;
        chk("onehot",  wr_onehot,     m_onehot);
        chk("mask",    written_mask,  m_mask);
        chk("count",   {16'h0, wr_count}, m_count & 32'hFFFF);
        chk("onehot4", wr_onehot4,    m_onehot);
        chk("mask4",   written_mask4, m_mask);
        chk("count4",  {28'h0, wr_count4}, m_count & 32'hF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb, da;
        logic [31:0] pre_a, pre_b, pre_d;
        logic [31:0] post_oh, post_mask;
        logic [15:0] post_cnt;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd0,  5'd1,  5'd31, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 16'd1};
        vt[1] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h8000_0000, 16'd1};
        vt[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 16'd1};
        vt[3] = '{1'b1, 5'd5,  32'h1,        5'd0,  5'd31, 5'd5,  32'h0, 32'hDEADBEEF, 32'h0, 32'h20, 32'h8000_0020, 16'd2};
        vt[4] = '{1'b0, 5'd9,  32'hFFFF0000, 5'd5,  5'd0,  5'd0,  32'h1, 32'h0, 32'h0, 32'h0, 32'h8000_0020, 16'd2};
        vt[5] = '{1'b1, 5'd1,  32'hA5A5A5A5, 5'd5,  5'd31, 5'd1,  32'h1, 32'hDEADBEEF, 32'h0, 32'h2, 32'h8000_0022, 16'd3};

        // Reset: everything reads back zero.
        #2;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            if (rdata_a !== 0 || rdata_b !== 0 || dbg_data !== 0) chk("reset_read", rdata_a | rdata_b | dbg_data, 32'h0);
            else n_cmp++;
        end
        chk("reset_mask",   written_mask, 32'h0);
        chk("reset_onehot", wr_onehot,    32'h0);
        chk("reset_count",  {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        for (int i = 0; i < 6; i++) begin
            drive(vt[i].w, vt[i].wa, vt[i].wd, vt[i].ra, vt[i].rb, vt[i].da);
            #1;
            chk($sformatf("vec%0d_a", i),   rdata_a,  vt[i].pre_a);
            chk($sformatf("vec%0d_b", i),   rdata_b,  vt[i].pre_b);
            chk($sformatf("vec%0d_dbg", i), dbg_data, vt[i].pre_d);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_oh", i),   wr_onehot,    vt[i].post_oh);
            chk($sformatf("vec%0d_mask", i), written_mask, vt[i].post_mask);
            chk($sformatf("vec%0d_cnt", i),  {16'h0, wr_count}, {16'h0, vt[i].post_cnt});
        end

        // Same-cycle read/write of reg 5 (old 1, new 2).
        drive(1'b1, 5'd5, 32'h2, 5'd0, 5'd5, 5'd5);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("rw5_same_b", rdata_b, 32'h2);
`else
        chk("rw5_same_b", rdata_b, 32'h1);
`endif
        chk("rw5_same_dbg", dbg_data, 32'h1);
        @(posedge clk); #1;
        chk("rw5_after_b", rdata_b, 32'h2);

        // Fill 1..31 with index, then reset while clock is low mid-write of reg 7.
        do_reset();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 5'(i));
            cycle_model();
        end
        drive(1'b1, 5'd7, 32'h77, 5'd31, 5'd7, 5'd30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a",    rdata_a,  32'h0);
        chk("arst_b",    rdata_b,  32'h0);
        chk("arst_dbg",  dbg_data, 32'h0);
        chk("arst_mask", written_mask, 32'h0);
        chk("arst_cnt",  {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        we = 1'b0; raddr_a = 5'd7;
        #1;
        chk("arst_reg7", rdata_a, 32'h0);
        drive(1'b1, 5'd3, 32'hCAFE0003, 5'd3, 5'd7, 5'd3);
        cycle_model();

        // Counter wrap on the 4-bit build; mask stays sticky.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 5'(i), 32'(i * 3), 5'(i), 5'd0, 5'd0);
            @(posedge clk);
        end
        #1;
        chk("wrap_count4", {28'h0, wr_count4}, 32'h1);
        chk("wrap_count",  {16'h0, wr_count},  32'd17);
        chk("wrap_mask4",  written_mask4, 32'h0003_FFFE);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            drive($urandom_range(0, 3) != 0, wa, $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
            cycle_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
